// File: rtl/cook_timer_ctrl_if.sv
// Interface bundling the cook timer's keypad, control and display signals.
interface cook_timer_ctrl_if;
    logic       tick_1hz;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic       mux_select;
    logic       load_pgt;
    logic       mag_on;
    logic       alarm;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;

    modport slave (
        input  tick_1hz, key_valid, key_digit, start, stop_clear, door_closed,
        output mux_select, load_pgt, mag_on, alarm,
               min_tens, min_ones, sec_tens, sec_ones
    );

    modport master (
        output tick_1hz, key_valid, key_digit, start, stop_clear, door_closed,
        input  mux_select, load_pgt, mag_on, alarm,
               min_tens, min_ones, sec_tens, sec_ones
    );
endinterface

// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer controller: keypad entry, BCD countdown, pause/resume
// and end-of-cook alarm, with all outputs registered.
module cook_timer_ctrl #(
    parameter int unsigned ALARM_TICKS = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    cook_timer_ctrl_if.slave  tmr
);
    localparam int unsigned DW = 4;
    localparam int unsigned SW = 3;

    localparam logic [SW-1:0] S_IDLE  = 3'd0;
    localparam logic [SW-1:0] S_SET   = 3'd1;
    localparam logic [SW-1:0] S_COOK  = 3'd2;
    localparam logic [SW-1:0] S_PAUSE = 3'd3;
    localparam logic [SW-1:0] S_DONE  = 3'd4;

    logic [SW-1:0] state_q, state_d;
    logic [DW-1:0] mt_q, mo_q, st_q, so_q;
    logic [DW-1:0] mt_d, mo_d, st_d, so_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          load_q, load_d;
    logic          mux_q, mag_q, alarm_q;

    logic [DW-1:0] dec_mt, dec_mo, dec_st, dec_so;
    logic          time_zero, dec_zero, key_ok;

    assign time_zero = ({mt_q, mo_q, st_q, so_q} == 16'd0);
    assign dec_zero  = ({dec_mt, dec_mo, dec_st, dec_so} == 16'd0);
    assign key_ok    = tmr.key_valid && (tmr.key_digit <= 4'd9);

    // One-second BCD decrement with seconds wrapping 00 -> 59.
    always_comb begin
        dec_mt = mt_q;
        dec_mo = mo_q;
        dec_st = st_q;
        dec_so = so_q;
        if (so_q != 4'd0) begin
            dec_so = so_q - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (st_q != 4'd0) begin
                dec_st = st_q - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (mo_q != 4'd0) begin
                    dec_mo = mo_q - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = mt_q - 4'd1;
                end
            end
        end
    end

    // Next-state logic; the first event in priority order that has an effect wins.
    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;

        if (tmr.stop_clear) begin
            if (state_q == S_COOK) begin
                state_d = S_PAUSE;
            end else begin
                state_d = S_IDLE;
                mt_d    = 4'd0;
                mo_d    = 4'd0;
                st_d    = 4'd0;
                so_d    = 4'd0;
                cnt_d   = 4'd0;
            end
        end else if (!tmr.door_closed && state_q == S_COOK) begin
            state_d = S_PAUSE;
        end else if (tmr.start && tmr.door_closed &&
                     ((state_q == S_SET && !time_zero) || state_q == S_PAUSE)) begin
            state_d = S_COOK;
        end else if (tmr.tick_1hz && state_q == S_COOK) begin
            if (!time_zero) begin
                mt_d = dec_mt;
                mo_d = dec_mo;
                st_d = dec_st;
                so_d = dec_so;
                if (dec_zero) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                end
            end
        end else if (tmr.tick_1hz && state_q == S_DONE) begin
            if (cnt_q == DW'(ALARM_TICKS - 1)) begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (key_ok && (state_q == S_IDLE || state_q == S_SET)) begin
            state_d = S_SET;
            load_d  = 1'b1;
            mt_d    = (state_q == S_IDLE) ? 4'd0 : mo_q;
            mo_d    = (state_q == S_IDLE) ? 4'd0 : st_q;
            st_d    = (state_q == S_IDLE) ? 4'd0 : so_q;
            so_d    = tmr.key_digit;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            cnt_q   <= 4'd0;
            load_q  <= 1'b0;
            mux_q   <= 1'b0;
            mag_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            mux_q   <= (state_d == S_COOK);
            mag_q   <= (state_d == S_COOK);
            alarm_q <= (state_d == S_DONE);
        end
    end

    assign tmr.mux_select = mux_q;
    assign tmr.load_pgt   = load_q;
    assign tmr.mag_on     = mag_q;
    assign tmr.alarm      = alarm_q;
    assign tmr.min_tens   = mt_q;
    assign tmr.min_ones   = mo_q;
    assign tmr.sec_tens   = st_q;
    assign tmr.sec_ones   = so_q;
endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Scoreboard bench for cook_timer_ctrl: directed scenarios plus random stimulus
// checked cycle by cycle against a time-as-integer reference model.
module tb_cook_timer_ctrl;
    typedef struct packed {
        logic        mux;
        logic        load;
        logic        mag;
        logic        alarm;
        logic [15:0] disp;
    } exp_t;

    typedef enum int {M_IDLE, M_SET, M_COOK, M_PAUSE, M_DONE} mstate_e;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    cook_timer_ctrl_if tif ();
    cook_timer_ctrl #(.ALARM_TICKS(3)) dut (.clock(clock), .reset_n(reset_n), .tmr(tif));

    exp_t    expq[$];
    int      checks = 0;
    int      failures = 0;
    mstate_e ms = M_IDLE;
    int      tval = 0;
    int      acnt = 0;
    bit      door_lvl = 1'b1;
    bit      done_flag = 1'b0;

    function automatic logic [15:0] to_disp(input int t);
        return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    // Reference: time held as a 4-digit decimal number MMSS.
    task automatic model_step(input bit rst, input bit sc, input bit door, input bit st,
                              input bit tk, input bit kv, input int kd);
        bit   ld = 1'b0;
        exp_t e;
        if (rst) begin
            ms = M_IDLE; tval = 0; acnt = 0;
        end else if (sc) begin
            if (ms == M_COOK) ms = M_PAUSE;
            else begin ms = M_IDLE; tval = 0; acnt = 0; end
        end else if (!door && ms == M_COOK) begin
            ms = M_PAUSE;
        end else if (st && door && ((ms == M_SET && tval != 0) || ms == M_PAUSE)) begin
            ms = M_COOK;
        end else if (tk && ms == M_COOK) begin
            if (tval != 0) begin
                if (tval % 100 != 0) tval = tval - 1;
                else tval = (tval / 100 - 1) * 100 + 59;
                if (tval == 0) begin ms = M_DONE; acnt = 0; end
            end
        end else if (tk && ms == M_DONE) begin
            acnt = acnt + 1;
            if (acnt == 3) begin ms = M_IDLE; acnt = 0; end
        end else if (kv && kd < 10 && (ms == M_IDLE || ms == M_SET)) begin
            if (ms == M_IDLE) tval = 0;
            tval = (tval * 10 + kd) % 10000;
            ms = M_SET;
            ld = 1'b1;
        end
        e.mux   = (ms == M_COOK);
        e.mag   = (ms == M_COOK);
        e.alarm = (ms == M_DONE);
        e.load  = ld;
        e.disp  = to_disp(tval);
        expq.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit sc, input bit st, input bit tk,
                       input bit kv, input int kd);
        @(negedge clock);
        reset_n             = ~rst;
        tif.stop_clear      = sc;
        tif.door_closed     = door_lvl;
        tif.start           = st;
        tif.tick_1hz        = tk;
        tif.key_valid       = kv;
        tif.key_digit       = 4'(kd);
        model_step(rst, sc, door_lvl, st, tk, kv, kd);
    endtask

    task automatic idle();       cyc(0, 0, 0, 0, 0, 0); endtask
    task automatic tick();       cyc(0, 0, 0, 1, 0, 0); endtask
    task automatic key(input int d); cyc(0, 0, 0, 0, 1, d); endtask
    task automatic start_req();  cyc(0, 0, 1, 0, 0, 0); endtask
    task automatic stop_req();   cyc(0, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0); endtask
    task automatic do_reset();   cyc(1, 0, 0, 0, 0, 0); endtask

    // Direct check of the outputs produced by the edge after the last cyc.
    task automatic chkd(input string nm, input logic [15:0] d, input bit mag,
                        input bit alm, input bit ld);
        logic [15:0] got;
        @(posedge clock);
        #1;
        got = {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};
        checks++;
        if (got !== d || tif.mag_on !== mag || tif.alarm !== alm || tif.load_pgt !== ld ||
            tif.mux_select !== mag) begin
            failures++;
            $display("FAIL %s: got disp=%h mag=%b mux=%b alarm=%b load=%b, expected disp=%h mag=%b mux=%b alarm=%b load=%b",
                     nm, got, tif.mag_on, tif.mux_select, tif.alarm, tif.load_pgt, d, mag, mag, alm, ld);
        end
    endtask

    // Scoreboard monitor: every edge consumes one expected output snapshot.
    initial begin
        exp_t e, g;
        forever begin
            @(posedge clock);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                g = '{mux: tif.mux_select, load: tif.load_pgt, mag: tif.mag_on,
                      alarm: tif.alarm,
                      disp: {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones}};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t: got mux=%b load=%b mag=%b alarm=%b disp=%h, expected mux=%b load=%b mag=%b alarm=%b disp=%h",
                             $time, g.mux, g.load, g.mag, g.alarm, g.disp,
                             e.mux, e.load, e.mag, e.alarm, e.disp);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        tif.tick_1hz = 0; tif.key_valid = 0; tif.key_digit = 0;
        tif.start = 0; tif.stop_clear = 0; tif.door_closed = 1;
        do_reset(); chkd("reset", 16'h0000, 0, 0, 0);
        do_reset();

        // Keys 1,3,0 then start and countdown.
        key(1); chkd("key1", 16'h0001, 0, 0, 1);
        idle();
        key(3); chkd("key3", 16'h0013, 0, 0, 1);
        key(0); chkd("key0", 16'h0130, 0, 0, 1);
        idle(); chkd("load_single", 16'h0130, 0, 0, 0);
        start_req(); chkd("cook_start", 16'h0130, 1, 0, 0);
        tick(); chkd("tick_0129", 16'h0129, 1, 0, 0);
        for (int i = 0; i < 30; i++) begin tick(); idle(); end
        chkd("tick_0059", 16'h0059, 1, 0, 0);
        key(7); chkd("key_in_cook", 16'h0059, 1, 0, 0);

        // Short cook to DONE and alarm duration.
        stop_req(); stop_req(); chkd("clear_idle", 16'h0000, 0, 0, 0);
        key(2); start_req(); tick(); idle();
        tick(); chkd("done", 16'h0000, 0, 1, 0);
        tick(); tick(); chkd("alarm_held", 16'h0000, 0, 1, 0);
        tick(); chkd("alarm_end", 16'h0000, 0, 0, 0);

        // Door opens coincident with a tick.
        key(1); key(0); start_req();
        door_lvl = 0; tick(); chkd("pause_door", 16'h0010, 0, 0, 0);
        door_lvl = 1; start_req(); chkd("resume", 16'h0010, 1, 0, 0);
        tick(); chkd("resume_tick", 16'h0009, 1, 0, 0);

        // Ignored starts and illegal digit; seconds tens above 5.
        stop_req(); stop_req();
        key(0); start_req(); chkd("start_zero", 16'h0000, 0, 0, 0);
        key(5); door_lvl = 0; start_req(); chkd("start_door_open", 16'h0005, 0, 0, 0);
        door_lvl = 1; key(12); chkd("illegal_digit", 16'h0005, 0, 0, 0);
        stop_req(); key(9); key(0); start_req(); tick(); chkd("sec_tens_9", 16'h0089, 1, 0, 0);

        // Reset mid-cook, then stop in PAUSE.
        stop_req(); stop_req(); key(4); key(5); start_req(); tick();
        do_reset(); chkd("reset_cook", 16'h0000, 0, 0, 0);
        key(9); start_req(); stop_req(); chkd("stop_to_pause", 16'h0009, 0, 0, 0);
        stop_req(); chkd("pause_clear", 16'h0000, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            bit rst, sc, st, tk, kv;
            int kd;
            if ($urandom_range(0, 19) == 0) door_lvl = ~door_lvl;
            rst = ($urandom_range(0, 599) == 0);
            sc  = ($urandom_range(0, 59) == 0);
            st  = ($urandom_range(0, 9) == 0);
            tk  = ($urandom_range(0, 3) == 0);
            kv  = ($urandom_range(0, 4) == 0);
            kd  = int'($urandom_range(0, 15));
            cyc(rst, sc, st, tk, kv, kd);
        end

        @(posedge clock);
        #2;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending, expected 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cook_timer_ctrl.md
COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
- REQ-001 Parameter ALARM_TICKS, default 3: number of tick_1hz pulses the alarm output stays high in DONE; legal range 1..15.
- REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
- REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
- REQ-004 tick_1hz  input  1  one-clock-cycle pulse, once per second, from the divided clock path.
- REQ-005 key_valid  input  1  one-cycle strobe: key_digit is valid this cycle.
- REQ-006 key_digit  input  4  BCD keypad digit; values 10..15 are illegal.
- REQ-007 start  input  1  one-cycle start request.
- REQ-008 stop_clear  input  1  one-cycle stop/clear request.
- REQ-009 door_closed  input  1  level; 1 = door closed.
- REQ-010 mux_select  output  1  to the time-source mux; 1 = 1 Hz countdown source, 0 = keypad load pulse source.
- REQ-011 load_pgt  output  1  one-cycle pulse per accepted digit; drives the mux pgt input.
- REQ-012 mag_on  output  1  magnetron enable.
- REQ-013 alarm  output  1  end-of-cook alarm.
- REQ-014 min_tens, min_ones, sec_tens, sec_ones  output  4 each  displayed time in BCD.

Function
- REQ-015 States: IDLE, SET, COOK, PAUSE, DONE; all outputs registered.
- REQ-016 Per-cycle input priority: stop_clear > door open > start > tick_1hz > key_valid; only the highest-priority applicable event acts in a cycle.
- REQ-017 IDLE: key_valid with digit 0..9 -> SET; time first cleared to 0000, then digit shifted in the same cycle.
- REQ-018 Digit entry (IDLE/SET): min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit; load_pgt high the following cycle for exactly one cycle.
- REQ-019 Digits 10..15 ignored in every state: no shift, no load_pgt.
- REQ-020 Key entries in COOK, PAUSE, DONE are ignored.
- REQ-021 SET: start with door_closed=1 and time != 0000 -> COOK; start with time 0000 or door open is ignored.
- REQ-022 SET: stop_clear -> IDLE, time cleared to 0000.
- REQ-023 COOK: each tick_1hz decrements time by one second in BCD; sec_ones borrows from sec_tens; seconds 00 -> 59 with minute borrow; min_ones borrows from min_tens.
- REQ-024 Seconds tens digits 6..9 accepted at entry and counted down normally (e.g. 0090 -> 0089).
- REQ-025 COOK: the tick that produces 0000 moves the state to DONE in the same edge; mag_on low from that edge.
- REQ-026 COOK: door_closed=0 or stop_clear -> PAUSE, time held; a simultaneous tick_1hz is discarded.
- REQ-027 PAUSE: start with door_closed=1 -> COOK; stop_clear -> IDLE, time cleared; start with door open ignored.
- REQ-028 DONE: alarm=1; counts ALARM_TICKS tick_1hz pulses then -> IDLE with alarm=0; stop_clear -> IDLE immediately.
- REQ-029 mux_select=1 only in COOK; mag_on=1 only in COOK; alarm=1 only in DONE.
- REQ-030 Time never underflows: no decrement at 0000 in any state.

Reset
- REQ-031 reset_n=0 at a clock edge -> state IDLE; time 0000; mux_select, load_pgt, mag_on, alarm all 0; alarm counter 0.
- REQ-032 Reset overrides every input and aborts any state, including COOK mid-countdown and DONE mid-alarm.

Verification
- REQ-033 Keys 1,3,0 then start, door closed -> display 0130, load_pgt 3 single-cycle pulses, mux_select=1, mag_on=1; after 1 tick 0129, after 31 ticks 0059.
- REQ-034 Entry 0002, start, 2 ticks -> 0000, DONE, mag_on=0, alarm=1 for 3 ticks, then IDLE, alarm=0.
- REQ-035 COOK at 0010; door_closed=0 coincident with tick -> PAUSE, display stays 0010; door closed + start -> COOK, next tick 0009.
- REQ-036 Start at 0000, and start with door open at 0005 -> both remain SET, mag_on=0; key_digit 12 -> no shift, no load_pgt.
- REQ-037 reset_n=0 during COOK at 0045 -> next edge IDLE, 0000, all control outputs 0; stop_clear in PAUSE -> IDLE, 0000.
